spi_pwm_bank: RTL and testbench
===============================

SPI_PWM_BANK -- requirements
Module: spi_pwm_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of PWM LED channels, 1..255.
REQ-002 SHALL have parameter BRIGHT_W, default 7: brightness width in bits, 1..8.
REQ-003 SHALL have parameter PWM_DIV, default 1: sysclk cycles per PWM counter tick, >=1.
REQ-004 SHALL have port sysclk, input, 1 bit: single system clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous to sysclk, active-low.
REQ-006 SHALL have port sclk, input, 1 bit: SPI clock, mode 0, asynchronous to sysclk.
REQ-007 SHALL have port cs, input, 1 bit: SPI chip select, active-low.
REQ-008 SHALL have port mosi, input, 1 bit: SPI serial data in, MSB first.
REQ-009 SHALL have port miso, output, 1 bit: SPI serial data out, MSB first.
REQ-010 SHALL have port led, output, NUM_CH bits: PWM outputs, bit i drives channel i.

Function
REQ-011 sclk, cs and mosi SHALL each pass a 2-flop synchroniser; edges SHALL be detected on the synchronised signals; sclk period >= 8 sysclk periods.
REQ-012 Frame = CMD byte, ADDR byte, then one or more PAYLOAD bytes, all while cs low; mosi sampled on sclk rising edge.
REQ-013 Commands: 0x00 NOP, 0x01 LED_SET, 0x02 LED_READ, 0x03 LED_BURST; any other CMD is treated as NOP.
REQ-014 FSM states: IDLE, CMD, ADDR, DATA, IGNORE; cs falling -> CMD; 8 bits -> ADDR; 8 bits -> DATA (or IGNORE for NOP/unknown CMD); cs rising from any state -> IDLE.
REQ-015 Brightness written = PAYLOAD[7:8-BRIGHT_W]; remaining low payload bits ignored.
REQ-016 LED_SET: on the 8th bit of the first PAYLOAD byte, brightness[ADDR] SHALL be written 1 sysclk after that sclk edge is detected; further payload bytes ignored.
REQ-017 LED_BURST: each completed PAYLOAD byte k SHALL write channel (ADDR+k) mod NUM_CH.
REQ-018 ADDR >= NUM_CH: LED_SET and LED_BURST SHALL write nothing for the whole frame.
REQ-019 LED_READ: on ADDR completion the shift-out register SHALL load {brightness[ADDR], zero padding} (0x00 if ADDR >= NUM_CH) within 3 sysclk; bits are shifted out during the first PAYLOAD byte.
REQ-020 miso changes only after a detected sclk falling edge; miso = 0 outside LED_READ payload and while cs high.
REQ-021 cs rising before a byte completes: the partial byte SHALL be discarded; no write occurs.
REQ-022 PWM counter: free-running 0..2^BRIGHT_W-2, advances once every PWM_DIV sysclk, wraps to 0.
REQ-023 led[i] = (counter < active[i]); 0 gives constant off; 2^BRIGHT_W-1 gives constant on.
REQ-024 Each channel SHALL keep a shadow brightness; active[i] loads from shadow only when the counter wraps to 0, so no period is truncated.
REQ-025 A write and a wrap in the same sysclk: the new value SHALL take effect at that wrap.

Reset
REQ-026 rst_n low at a sysclk edge: all shadow/active brightness = 0, led = 0, miso = 0, FSM = IDLE, PWM counter and divider = 0, synchronisers cleared.
REQ-027 After reset release with cs already low, the module SHALL stay in IDLE until cs is seen high; a frame in progress is ignored.

Verification
REQ-028 Frame 0x00,0x00,0x00 after reset -> all led stay 0; all brightness still 0.
REQ-029 Frame 0x01,0x00,0x14 (BRIGHT_W=7) -> brightness[0] = 0x0A; led[0] high 10 of 127 PWM ticks from the next period start.
REQ-030 Frame 0x03,0x06,0xFE,0xFE,0x02 (NUM_CH=8) -> ch6 = 0x7F (always on), ch7 = 0x7F, ch0 = 0x01; other channels unchanged.
REQ-031 Frame 0x01,0x10,0xFF -> no channel changes; then 0x02,0x07,0x00 -> miso returns 0xFE (ch7 = 0x7F); 0x02,0x10,0x00 -> 0x00.
REQ-032 cs raised after 4 payload bits of an LED_SET -> no write; rst_n low mid-frame -> all led 0, miso 0, following frames decoded normally.
REQ-033 Brightness write mid-period -> led waveform of the current period unchanged; new duty from the next counter wrap.

Source files
------------

// File: rtl/spi_pwm_bank.sv
// rtl/spi_pwm_bank.sv - SPI-programmed bank of PWM LED channels
// SPI pins are resynchronised into sysclk; frames write/read shadow brightness applied at PWM wrap.
module spi_pwm_bank #(
  parameter int NUM_CH   = 8,
  parameter int BRIGHT_W = 7,
  parameter int PWM_DIV  = 1
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic [NUM_CH-1:0] led
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [7:0]          NCH8     = 8'(NUM_CH);
  localparam logic [CH_W-1:0]     CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [BRIGHT_W-1:0] CNT_MAX  = BRIGHT_W'((1 << BRIGHT_W) - 2);
  localparam logic [DIV_W-1:0]    DIV_MAX  = DIV_W'(PWM_DIV - 1);
  localparam logic [7:0] CMD_SET = 8'h01, CMD_READ = 8'h02, CMD_BURST = 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE} state_t;

  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_d, cs_d;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t              state;
  logic [2:0]          bit_cnt;
  logic [6:0]          shreg;
  logic [7:0]          rx_byte, rd_byte, cmd, sout;
  logic                addr_ok, first;
  logic [3:0]          out_cnt;
  logic [CH_W-1:0]     ptr, wr_ch;
  logic                wr_en;
  logic [BRIGHT_W-1:0] wr_val;

  logic [BRIGHT_W-1:0] shadow [NUM_CH];
  logic [BRIGHT_W-1:0] active [NUM_CH];
  logic [BRIGHT_W-1:0] cnt;
  logic [DIV_W-1:0]    div;

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign cs_rise   = cs_sync[1] & ~cs_d;
  assign cs_fall   = ~cs_sync[1] & cs_d;
  assign rx_byte   = {shreg, mosi_sync[1]};

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  // Read-back value, left-aligned so the MSB of brightness is the first bit out
  always_comb begin
    rd_byte = 8'h00;
    if (rx_byte < NCH8) rd_byte = 8'(shadow[rx_byte[CH_W-1:0]]) << (8 - BRIGHT_W);
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      cmd     <= '0;
      addr_ok <= 1'b0;
      first   <= 1'b0;
      sout    <= '0;
      out_cnt <= '0;
      ptr     <= '0;
      wr_ch   <= '0;
      wr_en   <= 1'b0;
      wr_val  <= '0;
      miso    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (cs_rise) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else if (cs_fall) begin
        state   <= S_CMD;
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else begin
        if (state != S_IDLE && sclk_rise) begin
          shreg   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          S_CMD: if (sclk_rise && bit_cnt == 3'd7) begin
            cmd   <= rx_byte;
            state <= S_ADDR;
          end
          S_ADDR: if (sclk_rise && bit_cnt == 3'd7) begin
            addr_ok <= rx_byte < NCH8;
            ptr     <= rx_byte[CH_W-1:0];
            sout    <= rd_byte;
            out_cnt <= '0;
            first   <= 1'b1;
            state   <= (cmd == CMD_SET || cmd == CMD_READ || cmd == CMD_BURST) ? S_DATA : S_IGNORE;
          end
          S_DATA: begin
            if (sclk_rise && bit_cnt == 3'd7) begin
              first <= 1'b0;
              if (addr_ok && ((cmd == CMD_SET && first) || cmd == CMD_BURST)) begin
                wr_en  <= 1'b1;
                wr_ch  <= ptr;
                wr_val <= rx_byte[7 -: BRIGHT_W];
              end
              if (cmd == CMD_BURST) ptr <= (ptr == CH_LAST) ? '0 : ptr + 1'b1;
            end
            if (sclk_fall && cmd == CMD_READ) begin
              if (out_cnt < 4'd8) begin
                miso    <= sout[7];
                sout    <= {sout[6:0], 1'b0};
                out_cnt <= out_cnt + 4'd1;
              end else begin
                miso <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A write landing on the wrap cycle is forwarded straight into active
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      div <= '0;
      cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_en) shadow[wr_ch] <= wr_val;
      if (div == DIV_MAX) begin
        div <= '0;
        if (cnt == CNT_MAX) begin
          cnt <= '0;
          for (int i = 0; i < NUM_CH; i++)
            active[i] <= (wr_en && wr_ch == CH_W'(i)) ? wr_val : shadow[i];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) led[i] = cnt < active[i];
  end

endmodule

// File: tb/tb_spi_pwm_bank.sv
// tb/tb_spi_pwm_bank.sv - directed scoreboard bench for spi_pwm_bank
`timescale 1ns/1ps
module tb_spi_pwm_bank;
  localparam int NCH    = 8;
  localparam int BW     = 7;
  localparam int DIV    = 4;
  localparam int PERIOD = ((1 << BW) - 1) * DIV;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  logic sclk   = 1'b0;
  logic cs     = 1'b1;
  logic mosi   = 1'b0;
  logic miso;
  logic [NCH-1:0] led;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int bright_m[NCH];
  logic [7:0] rx;

  always #5 sysclk = ~sysclk;

  spi_pwm_bank #(.NUM_CH(NCH), .BRIGHT_W(BW), .PWM_DIV(DIV)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .sclk(sclk), .cs(cs),
    .mosi(mosi), .miso(miso), .led(led)
  );

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      #50 sclk = 1'b1;
      r[i] = miso;
      #50 sclk = 1'b0;
    end
  endtask

  // Returns the byte clocked in during the first payload byte
  task automatic frame(input logic [7:0] b [5], input int n, output logic [7:0] rx2);
    logic [7:0] r;
    rx2 = 8'h00;
    @(negedge sysclk);
    cs = 1'b0;
    #50;
    for (int k = 0; k < n; k++) begin
      spi_byte(b[k], 8, r);
      if (k == 2) rx2 = r;
    end
    #50 cs = 1'b1;
    #200;
  endtask

  task automatic set_model(input int ch, input int payload);
    bright_m[ch] = payload >> (8 - BW);
  endtask

  task automatic read_check(input string tag, input logic [7:0] addr, input int expv);
    logic [7:0] r;
    exp_q.push_back(expv);
    frame('{8'h02, addr, 8'h00, 8'h00, 8'h00}, 3, r);
    check(tag, int'(r), exp_q.pop_front());
  endtask

  task automatic check_duty(input string tag);
    int hi [NCH];
    repeat (PERIOD + 20) @(negedge sysclk);
    for (int i = 0; i < NCH; i++) begin
      exp_q.push_back(bright_m[i] * DIV);
      hi[i] = 0;
    end
    repeat (PERIOD) begin
      @(negedge sysclk);
      for (int i = 0; i < NCH; i++) hi[i] += int'(led[i]);
    end
    for (int i = 0; i < NCH; i++) check($sformatf("%s_ch%0d", tag, i), hi[i], exp_q.pop_front());
  endtask

  // Advance to the first cycle of a PWM period, marked by led[0] rising (ch0 duty 1)
  task automatic sync_period(output int found, output int hi2);
    logic prev;
    found = 0;
    hi2   = 0;
    @(negedge sysclk);
    prev = led[0];
    for (int n = 0; n < 2 * PERIOD; n++) begin
      @(negedge sysclk);
      if (led[0] && !prev) begin
        found = 1;
        break;
      end
      hi2 += int'(led[2]);
      prev = led[0];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int found, hi2, hi_full;
    logic [7:0] r;
    for (int i = 0; i < NCH; i++) bright_m[i] = 0;

    repeat (5) @(negedge sysclk);
    check("reset_led", int'(led), 0);
    check("reset_miso", int'(miso), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge sysclk);

    frame('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, r);
    check_duty("nop");

    frame('{8'h01, 8'h00, 8'h14, 8'h00, 8'h00}, 3, r);
    set_model(0, 8'h14);
    check_duty("set");
    read_check("read_ch0", 8'h00, 8'h14);

    frame('{8'h03, 8'h06, 8'hFE, 8'hFE, 8'h02}, 5, r);
    set_model(6, 8'hFE);
    set_model(7, 8'hFE);
    set_model(0, 8'h02);
    check_duty("burst");

    frame('{8'h01, 8'h10, 8'hFF, 8'h00, 8'h00}, 3, r);
    check_duty("oor");
    read_check("read_ch7", 8'h07, 8'hFE);
    read_check("read_oor", 8'h10, 8'h00);

    // LED_SET aborted after 4 payload bits
    @(negedge sysclk);
    cs = 1'b0;
    #50;
    spi_byte(8'h01, 8, r);
    spi_byte(8'h01, 8, r);
    spi_byte(8'hFE, 4, r);
    #50 cs = 1'b1;
    #200;
    read_check("partial_ch1", 8'h01, 8'h00);
    read_check("partial_ch0", 8'h00, 8'h02);

    // Mid-period write must not disturb the running period
    sync_period(found, hi2);
    check("sync_found", found, 1);
    frame('{8'h01, 8'h02, 8'hFE, 8'h00, 8'h00}, 3, r);
    set_model(2, 8'hFE);
    exp_q.push_back(0);
    sync_period(found, hi2);
    check("midperiod_found", found, 1);
    check("midperiod_ch2", hi2, exp_q.pop_front());
    exp_q.push_back(PERIOD);
    hi_full = int'(led[2]);
    repeat (PERIOD - 1) begin
      @(negedge sysclk);
      hi_full += int'(led[2]);
    end
    check("nextperiod_ch2", hi_full, exp_q.pop_front());

    // Reset in the middle of a frame, then a frame already in progress is ignored
    @(negedge sysclk);
    cs = 1'b0;
    #50;
    spi_byte(8'h01, 8, r);
    spi_byte(8'h00, 4, r);
    @(negedge sysclk);
    rst_n = 1'b0;
    repeat (3) @(negedge sysclk);
    check("midrst_led", int'(led), 0);
    check("midrst_miso", int'(miso), 0);
    rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) bright_m[i] = 0;
    repeat (5) @(negedge sysclk);
    spi_byte(8'h01, 8, r);
    spi_byte(8'h04, 8, r);
    spi_byte(8'hFE, 8, r);
    #50 cs = 1'b1;
    #200;
    check_duty("postrst");

    frame('{8'h01, 8'h03, 8'h80, 8'h00, 8'h00}, 3, r);
    set_model(3, 8'h80);
    check_duty("recover");
    read_check("read_ch3", 8'h03, 8'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
